// File: rtl/axi_burst_responder.sv
// Target-side burst responder: stores write bursts in a byte-lane memory and returns read bursts.
// WRAP bursts are built only when BURST_RESP_WRAP_EN is defined; otherwise btyp=10 is rejected.
module axi_burst_responder #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned DEPTH = 256
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              transfer,
  input  logic              wr,
  input  logic [8:0]        bsize,
  input  logic [5:0]        blen,
  input  logic [1:0]        btyp,
  input  logic [SIZE*8-1:0] wadd,
  input  logic [SIZE*8-1:0] radd,
  input  logic [SIZE*8-1:0] datain,
  input  logic              dvalid,
  input  logic              dlast,
  output logic [SIZE*8-1:0] dataout,
  output logic              rvalid,
  output logic              rlast,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int unsigned AW   = SIZE * 8;
  localparam int unsigned IDXW = $clog2(DEPTH);

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;
`ifdef BURST_RESP_WRAP_EN
  localparam logic [1:0] BT_WRAP  = 2'b10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RDRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d, addr_nxt, addr_inc, start_addr, lane_lo;
  logic [5:0]      beat_q, beat_d, blen_q, blen_d;
  logic [8:0]      bsize_q, bsize_d;
  logic [1:0]      btyp_q, btyp_d;
  logic            rvalid_d, rlast_d, done_d, err_d;
  logic            mem_we, last_beat;
  logic            size_ok, align_ok, type_ok, req_legal;
  logic [IDXW-1:0] word_idx;
  logic [SIZE-1:0] lane_en;
  logic [AW-1:0]   mem [DEPTH];

  // Request legality, evaluated on the live request inputs in IDLE
  assign start_addr = wr ? wadd : radd;
  assign size_ok    = (bsize != 9'd0) && ((bsize & (bsize - 9'd1)) == 9'd0) && (bsize <= 9'(SIZE));
  assign align_ok   = (start_addr & (AW'(bsize) - AW'(1))) == '0;
`ifdef BURST_RESP_WRAP_EN
  assign type_ok    = (btyp == BT_FIXED) || (btyp == BT_INCR) ||
                      ((btyp == BT_WRAP) &&
                       ((blen == 6'd1) || (blen == 6'd3) || (blen == 6'd7) || (blen == 6'd15)));
`else
  assign type_ok    = (btyp == BT_FIXED) || (btyp == BT_INCR);
`endif
  assign req_legal  = size_ok && align_ok && type_ok;

  assign last_beat  = (beat_q == blen_q);
  assign addr_inc   = addr_q + AW'(bsize_q);

`ifdef BURST_RESP_WRAP_EN
  logic [AW-1:0] wrap_mask;
  // Wrap window is bsize*(blen+1) bytes, aligned to its own size
  assign wrap_mask = (AW'(bsize_q) * (AW'(blen_q) + AW'(1))) - AW'(1);
  always_comb begin
    if (btyp_q == BT_WRAP)       addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    else if (btyp_q == BT_FIXED) addr_nxt = addr_q;
    else                         addr_nxt = addr_inc;
  end
`else
  assign addr_nxt = (btyp_q == BT_FIXED) ? addr_q : addr_inc;
`endif

  // Word select and active byte lanes for the current beat address
  assign word_idx = IDXW'(addr_q / AW'(SIZE));
  assign lane_lo  = addr_q % AW'(SIZE);
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < SIZE; i++) begin
      lane_en[i] = (AW'(i) >= lane_lo) && (AW'(i) < lane_lo + AW'(bsize_q));
    end
  end

  // Byte-lane memory; never reset
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < SIZE; i++) begin
        if (lane_en[i]) mem[word_idx][i*8 +: 8] <= datain[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    bsize_d  = bsize_q;
    blen_d   = blen_q;
    btyp_d   = btyp_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          if (req_legal) begin
            state_d = wr ? S_WRITE : S_READ;
            addr_d  = start_addr;
            beat_d  = '0;
            bsize_d = bsize;
            blen_d  = blen;
            btyp_d  = btyp;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (dvalid) begin
          mem_we = ~resetn;
          // Early or missing dlast still writes the beat, then ends the burst with err
          if (dlast || last_beat) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = dlast ^ last_beat;
          end else begin
            addr_d = addr_nxt;
            beat_d = beat_q + 6'd1;
          end
        end
      end
      S_READ: begin
        rvalid_d = 1'b1;
        rlast_d  = last_beat;
        if (last_beat) begin
          state_d = S_RDRAIN;
        end else begin
          addr_d = addr_nxt;
          beat_d = beat_q + 6'd1;
        end
      end
      S_RDRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      bsize_q <= '0;
      blen_q  <= '0;
      btyp_q  <= '0;
      dataout <= '0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      bsize_q <= bsize_d;
      blen_q  <= blen_d;
      btyp_q  <= btyp_d;
      rvalid  <= rvalid_d;
      rlast   <= rlast_d;
      busy    <= (state_d != S_IDLE);
      done    <= done_d;
      err     <= err_d;
      if (state_q == S_READ) dataout <= mem[word_idx];
    end
  end

endmodule

// File: tb/tb_axi_burst_responder.sv
// Self-checking bench for axi_burst_responder: scoreboard of expected read words from a byte-lane model.
`timescale 1ns/1ps
module tb_axi_burst_responder;
  logic        aclk = 1'b0;
  logic        resetn;
  logic        transfer, wr, dvalid, dlast;
  logic [8:0]  bsize;
  logic [5:0]  blen;
  logic [1:0]  btyp;
  logic [31:0] wadd, radd, datain;
  logic [31:0] dataout;
  logic        rvalid, rlast, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] wq [$];
  logic [31:0] exp_q [$];
  logic [31:0] obs_data [$];
  int          obs_cyc [$];
  logic        obs_last [$];
  int          done_cyc, err_cyc, busy_lo, busy_hi;
  logic        busy_c1, busy_at_done;

  always #5 aclk = ~aclk;

  axi_burst_responder #(.SIZE(4), .DEPTH(256)) dut (
    .aclk(aclk), .resetn(resetn), .transfer(transfer), .wr(wr),
    .bsize(bsize), .blen(blen), .btyp(btyp), .wadd(wadd), .radd(radd),
    .datain(datain), .dvalid(dvalid), .dlast(dlast), .dataout(dataout),
    .rvalid(rvalid), .rlast(rlast), .busy(busy), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a, input int bs, input int bl,
                                      input logic [1:0] bt);
    logic [31:0] total, base;
    if (bt == 2'b00) return a;
    if (bt == 2'b10) begin
      total = 32'(bs * (bl + 1));
      base  = a - (a % total);
      return base + ((a - base + 32'(bs)) % total);
    end
    return a + 32'(bs);
  endfunction

  task automatic model_write(input logic [31:0] a0, input int bs, input int bl,
                             input logic [1:0] bt, input int nb);
    logic [31:0] a;
    int w, lo;
    a = a0;
    for (int b = 0; b < nb; b++) begin
      w  = int'((a / 4) % 256);
      lo = int'(a % 4);
      for (int l = lo; l < lo + bs; l++) ref_mem[w][l*8 +: 8] = wq[b][l*8 +: 8];
      a = nxt(a, bs, bl, bt);
    end
  endtask

  task automatic exp_read(input logic [31:0] a0, input int bs, input int bl, input logic [1:0] bt);
    logic [31:0] a;
    a = a0;
    for (int k = 0; k <= bl; k++) begin
      exp_q.push_back(ref_mem[int'((a / 4) % 256)]);
      a = nxt(a, bs, bl, bt);
    end
  endtask

  task automatic wr_burst(input logic [31:0] a, input int bs, input int bl, input logic [1:0] bt,
                          input int nb, input int dl_at);
    int c;
    done_cyc = -1; err_cyc = -1; busy_at_done = 1'bx;
    wadd = a; bsize = 9'(bs); blen = 6'(bl); btyp = bt; wr = 1'b1; transfer = 1'b1;
    tick();
    transfer = 1'b0;
    c = 1;
    busy_c1 = busy;
    if (err) err_cyc = c;
    for (int b = 0; b < nb + 2; b++) begin
      if (b < nb) begin
        dvalid = 1'b1; datain = wq[b]; dlast = (b + 1 == dl_at);
      end else begin
        dvalid = 1'b0; datain = '0; dlast = 1'b0;
      end
      tick();
      c++;
      if (done && done_cyc < 0) begin done_cyc = c; busy_at_done = busy; end
      if (err && err_cyc < 0) err_cyc = c;
    end
    dvalid = 1'b0; dlast = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] a, input int bs, input int bl, input logic [1:0] bt);
    obs_data.delete(); obs_cyc.delete(); obs_last.delete();
    done_cyc = -1; err_cyc = -1; busy_lo = -1; busy_hi = -1;
    radd = a; bsize = 9'(bs); blen = 6'(bl); btyp = bt; wr = 1'b0; transfer = 1'b1;
    for (int c = 1; c <= bl + 8; c++) begin
      tick();
      transfer = 1'b0;
      if (rvalid) begin obs_data.push_back(dataout); obs_cyc.push_back(c); obs_last.push_back(rlast); end
      if (done && done_cyc < 0) done_cyc = c;
      if (err && err_cyc < 0) err_cyc = c;
      if (busy) begin if (busy_lo < 0) busy_lo = c; busy_hi = c; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    tick(); tick();
    checks++;
    if ({rvalid, rlast, busy, done, err} !== 5'b0 || dataout !== 32'h0) begin
      errors++;
      $display("FAIL reset flags=%b dataout=%h, required 00000 00000000",
               {rvalid, rlast, busy, done, err}, dataout);
    end
    resetn = 1'b0;
    tick();
  endtask

  task automatic test_preload();
    wq.delete();
    for (int i = 0; i < 32; i++) wq.push_back($urandom);
    wr_burst(32'h0, 4, 31, 2'b01, 32, 32);
    checks++;
    if (busy_c1 !== 1'b1 || done_cyc != 33 || err_cyc != -1 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL preload busy1=%b done_cyc=%0d err_cyc=%0d busy_done=%b, required 1 33 -1 0",
               busy_c1, done_cyc, err_cyc, busy_at_done);
    end
    model_write(32'h0, 4, 31, 2'b01, 32);
  endtask

  task automatic test_incr();
    logic [31:0] e;
    wq.delete();
    wq.push_back(32'h11111111); wq.push_back(32'h22222222);
    wq.push_back(32'h33333333); wq.push_back(32'h44444444);
    wr_burst(32'h10, 4, 3, 2'b01, 4, 4);
    checks++;
    if (busy_c1 !== 1'b1 || done_cyc != 5 || err_cyc != -1 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL incr_write busy1=%b done_cyc=%0d err_cyc=%0d busy_done=%b, required 1 5 -1 0",
               busy_c1, done_cyc, err_cyc, busy_at_done);
    end
    model_write(32'h10, 4, 3, 2'b01, 4);
    exp_read(32'h10, 4, 3, 2'b01);
    rd_burst(32'h10, 4, 3, 2'b01);
    checks++;
    if (obs_data.size() != 4 || done_cyc != 6 || busy_lo != 1 || busy_hi != 5) begin
      errors++;
      $display("FAIL incr_read_frame beats=%0d done_cyc=%0d busy=%0d..%0d, required 4 6 1..5",
               obs_data.size(), done_cyc, busy_lo, busy_hi);
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (k >= obs_data.size() || obs_data[k] !== e || obs_cyc[k] != k + 2 || obs_last[k] !== (k == 3)) begin
        errors++;
        $display("FAIL incr_read beat%0d got=%h cyc=%0d last=%b, required %h cyc=%0d last=%b",
                 k, obs_data[k], obs_cyc[k], obs_last[k], e, k + 2, (k == 3));
      end
    end
  endtask

  task automatic test_narrow_fixed();
    logic [31:0] old8, e, want8;
    old8 = ref_mem[8];
    wq.delete();
    wq.push_back(32'hAABBCCDD); wq.push_back(32'h00EE0000);
    wr_burst(32'h21, 1, 1, 2'b00, 2, 2);
    checks++;
    if (done_cyc != 3 || err_cyc != -1) begin
      errors++;
      $display("FAIL narrow_write done_cyc=%0d err_cyc=%0d, required 3 -1", done_cyc, err_cyc);
    end
    model_write(32'h21, 1, 1, 2'b00, 2);
    want8 = {old8[31:16], 8'h00, old8[7:0]};
    exp_read(32'h1C, 4, 2, 2'b01);
    rd_burst(32'h1C, 4, 2, 2'b01);
    checks++;
    if (obs_data.size() != 3 || obs_data[1] !== want8) begin
      errors++;
      $display("FAIL narrow_lane beats=%0d word8=%h, required 3 %h", obs_data.size(), obs_data[1], want8);
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (k >= obs_data.size() || obs_data[k] !== e) begin
        errors++;
        $display("FAIL narrow_read beat%0d got=%h, required %h", k, obs_data[k], e);
      end
    end
  endtask

  task automatic test_wrap();
`ifdef BURST_RESP_WRAP_EN
    logic [31:0] e;
    exp_q.push_back(ref_mem[14]); exp_q.push_back(ref_mem[15]);
    exp_q.push_back(ref_mem[12]); exp_q.push_back(ref_mem[13]);
    rd_burst(32'h38, 4, 3, 2'b10);
    checks++;
    if (obs_data.size() != 4 || err_cyc != -1 || done_cyc != 6) begin
      errors++;
      $display("FAIL wrap_frame beats=%0d err_cyc=%0d done_cyc=%0d, required 4 -1 6",
               obs_data.size(), err_cyc, done_cyc);
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (k >= obs_data.size() || obs_data[k] !== e || obs_last[k] !== (k == 3)) begin
        errors++;
        $display("FAIL wrap_read beat%0d got=%h last=%b, required %h last=%b",
                 k, obs_data[k], obs_last[k], e, (k == 3));
      end
    end
`else
    rd_burst(32'h38, 4, 3, 2'b10);
    checks++;
    if (obs_data.size() != 0 || err_cyc != 1 || busy_lo != -1) begin
      errors++;
      $display("FAIL wrap_disabled beats=%0d err_cyc=%0d busy_first=%0d, required 0 1 -1",
               obs_data.size(), err_cyc, busy_lo);
    end
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] e;
    logic [31:0] ad [3];
    int          bs [3];
    logic [1:0]  bt [3];
    ad[0] = 32'h40; bs[0] = 4; bt[0] = 2'b11;
    ad[1] = 32'h40; bs[1] = 3; bt[1] = 2'b01;
    ad[2] = 32'h02; bs[2] = 4; bt[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      wadd = ad[i]; bsize = 9'(bs[i]); blen = 6'd0; btyp = bt[i]; wr = 1'b1; transfer = 1'b1;
      dvalid = 1'b1; dlast = 1'b1; datain = 32'hDEADBEEF;
      tick();
      transfer = 1'b0; dvalid = 1'b0; dlast = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d_t1 err=%b busy=%b, required 1 0", i, err, busy);
      end
      tick();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d_t2 err=%b busy=%b, required 0 0", i, err, busy);
      end
    end
    exp_read(32'h0, 4, 16, 2'b01);
    rd_burst(32'h0, 4, 16, 2'b01);
    for (int k = 0; k < 17; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (k >= obs_data.size() || obs_data[k] !== e) begin
        errors++;
        $display("FAIL illegal_mem word%0d got=%h, required %h", k, obs_data[k], e);
      end
    end
  endtask

  task automatic test_framing();
    logic [31:0] e;
    wq.delete();
    wq.push_back(32'hA5A5A5A5); wq.push_back(32'h5A5A5A5A);
    wr_burst(32'h50, 4, 3, 2'b01, 2, 2);
    checks++;
    if (err_cyc != 3 || done_cyc != 3 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL early_dlast err_cyc=%0d done_cyc=%0d busy=%b, required 3 3 0",
               err_cyc, done_cyc, busy_at_done);
    end
    model_write(32'h50, 4, 3, 2'b01, 2);
    exp_read(32'h50, 4, 3, 2'b01);
    rd_burst(32'h50, 4, 3, 2'b01);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (k >= obs_data.size() || obs_data[k] !== e) begin
        errors++;
        $display("FAIL early_dlast_mem beat%0d got=%h, required %h", k, obs_data[k], e);
      end
    end
    wq.delete();
    wq.push_back(32'hC3C3C3C3); wq.push_back(32'h3C3C3C3C);
    wr_burst(32'h60, 4, 1, 2'b01, 2, 0);
    checks++;
    if (err_cyc != 3 || done_cyc != 3 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL missing_dlast err_cyc=%0d done_cyc=%0d busy=%b, required 3 3 0",
               err_cyc, done_cyc, busy_at_done);
    end
    model_write(32'h60, 4, 1, 2'b01, 2);
    exp_read(32'h60, 4, 1, 2'b01);
    rd_burst(32'h60, 4, 1, 2'b01);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (k >= obs_data.size() || obs_data[k] !== e) begin
        errors++;
        $display("FAIL missing_dlast_mem beat%0d got=%h, required %h", k, obs_data[k], e);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] e;
    radd = 32'h0; bsize = 9'd4; blen = 6'd7; btyp = 2'b01; wr = 1'b0; transfer = 1'b1;
    tick();
    transfer = 1'b0;
    tick(); tick();
    checks++;
    if (rvalid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midread_active rvalid=%b busy=%b, required 1 1", rvalid, busy);
    end
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    checks++;
    if ({rvalid, rlast, busy, done, err} !== 5'b0 || dataout !== 32'h0) begin
      errors++;
      $display("FAIL midread_reset flags=%b dataout=%h, required 00000 00000000",
               {rvalid, rlast, busy, done, err}, dataout);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midread_idle rvalid=%b busy=%b done=%b, required 0 0 0", rvalid, busy, done);
    end
    exp_read(32'h14, 4, 0, 2'b01);
    rd_burst(32'h14, 4, 0, 2'b01);
    e = exp_q.pop_front();
    checks++;
    if (obs_data.size() != 1 || obs_data[0] !== e || obs_cyc[0] != 2 || done_cyc != 3) begin
      errors++;
      $display("FAIL midread_restart beats=%0d data=%h cyc=%0d done_cyc=%0d, required 1 %h 2 3",
               obs_data.size(), obs_data[0], obs_cyc[0], done_cyc, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    exp_read(32'h10, 4, 0, 2'b01);
    exp_read(32'h54, 4, 0, 2'b01);
    radd = 32'h10; bsize = 9'd4; blen = 6'd0; btyp = 2'b01; wr = 1'b0; transfer = 1'b1;
    tick();
    transfer = 1'b0;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rlast !== 1'b1 || dataout !== e) begin
      errors++;
      $display("FAIL b2b_first rvalid=%b rlast=%b data=%h, required 1 1 %h", rvalid, rlast, dataout, e);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done done=%b busy=%b, required 1 0", done, busy);
    end
    radd = 32'h54; transfer = 1'b1;
    tick();
    transfer = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy=%b, required 1", busy);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || dataout !== e) begin
      errors++;
      $display("FAIL b2b_second rvalid=%b data=%h, required 1 %h", rvalid, dataout, e);
    end
    tick(); tick();
  endtask

  initial begin
    transfer = 1'b0; wr = 1'b0; dvalid = 1'b0; dlast = 1'b0;
    bsize = '0; blen = '0; btyp = '0; wadd = '0; radd = '0; datain = '0;
    test_reset();
    test_preload();
    test_incr();
    test_narrow_fixed();
    test_wrap();
    test_illegal();
    test_framing();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
